// File: rtl/seq_ctr_ctrl_if.sv
// rtl/seq_ctr_ctrl_if.sv - control/status bundle for the counter/sequencer controller
interface seq_ctr_ctrl_if #(
  parameter int PRE_W = 6,
  parameter int CNT_W = 4,
  parameter int NCH   = 2
);
  logic             clr;
  logic [NCH-1:0]   tgl;
  logic [NCH-1:0]   tq;
  logic [PRE_W-1:0] pre;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       state;
  logic             pre_tc;
  logic             done_p;

  modport master (
    output clr, tgl,
    input  tq, pre, cnt, state, pre_tc, done_p
  );

  modport slave (
    input  clr, tgl,
    output tq, pre, cnt, state, pre_tc, done_p
  );
endinterface

// File: rtl/seq_ctr_ctrl.sv
// rtl/seq_ctr_ctrl.sv - toggle channels, prescaler and cascaded event counter under a 4-state FSM
module seq_ctr_ctrl #(
  parameter int PRE_W = 6,
  parameter int CNT_W = 4,
  parameter int LIMIT = 10,
  parameter int NCH   = 2
) (
  input  logic          clk,
  input  logic          rst,
  seq_ctr_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Last legal count value; reaching it on a terminal count ends the run.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

  state_t           state_q, state_d;
  logic [NCH-1:0]   tq_q, tq_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic pause;
  logic tc_raw;
  logic pre_tc;

  // The highest channel acts as pause; FSM only looks at registered toggle state.
  assign pause  = tq_q[NCH-1];
  assign tc_raw = &pre_q;
  assign pre_tc = (state_q == ST_RUN) & ~pause & tc_raw;

  // Next-state: toggles, FSM transitions and counter updates; clear overrides all.
  always_comb begin
    state_d = state_q;
    tq_d    = tq_q ^ bus.tgl;
    pre_d   = pre_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (tq_q[0]) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (pause) begin
          state_d = ST_HOLD;
        end else begin
          // Prescaler wraps to 0 on its own at terminal count.
          pre_d = pre_q + PRE_W'(1);
          if (tc_raw) begin
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              state_d = ST_DONE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      ST_HOLD: begin
        if (!pause) state_d = ST_RUN;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (bus.clr) begin
      state_d = ST_IDLE;
      tq_d    = '0;
      pre_d   = '0;
      cnt_d   = '0;
    end
  end

  // State and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tq_q    <= '0;
      pre_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tq_q    <= tq_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.tq     = tq_q;
  assign bus.pre    = pre_q;
  assign bus.cnt    = cnt_q;
  assign bus.state  = state_q;
  assign bus.pre_tc = pre_tc;
  assign bus.done_p = (state_q == ST_DONE);

endmodule
